// File: rtl/wb_pkg.sv
// Shared Wishbone definitions for the line buffer: FSM encoding, burst
// cycle-type / burst-type codes and a byte-lane merge helper.
package wb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } lb_state_e;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;
    localparam logic [1:0] BTE_LINEAR  = 2'b00;

    function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  sel);
        logic [31:0] merged;
        for (int i = 0; i < 4; i++) begin
            merged[8*i +: 8] = sel[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/wb_line_buffer.sv
// Single-line read buffer between a classic Wishbone CPU port and a B3 burst
// SDRAM port: read misses fill a whole line, writes pass straight through.
module wb_line_buffer
    import wb_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WORDS = 8
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    input  logic                  wbs_cyc_i,
    input  logic                  wbs_stb_i,
    input  logic                  wbs_we_i,
    input  logic [ADDR_WIDTH-1:0] wbs_adr_i,
    input  logic [31:0]           wbs_dat_i,
    input  logic [3:0]            wbs_sel_i,
    output logic [31:0]           wbs_dat_o,
    output logic                  wbs_ack_o,
    output logic                  wbs_err_o,
    output logic                  wbm_cyc_o,
    output logic                  wbm_stb_o,
    output logic                  wbm_we_o,
    output logic [ADDR_WIDTH-1:0] wbm_adr_o,
    output logic [31:0]           wbm_dat_o,
    output logic [3:0]            wbm_sel_o,
    output logic [2:0]            wbm_cti_o,
    output logic [1:0]            wbm_bte_o,
    input  logic [31:0]           wbm_dat_i,
    input  logic                  wbm_ack_i,
    input  logic                  wbm_err_i,
    input  logic                  flush_i
);

    localparam int WORD_W = $clog2(LINE_WORDS);
    localparam int OFF_W  = WORD_W + 2;
    localparam int TAG_W  = ADDR_WIDTH - OFF_W;
    localparam logic [WORD_W-1:0] LAST_BEAT = WORD_W'(LINE_WORDS - 1);

    lb_state_e           state_reg, state_next;
    logic                valid_reg, valid_next;
    logic                ack_reg, ack_next;
    logic                err_reg, err_next;
    logic                abort_reg, abort_next;
    logic                flush_pend_reg, flush_pend_next;
    logic [WORD_W-1:0]   beat_reg, beat_next;

    logic [TAG_W-1:0]      tag_reg;
    logic [31:0]           line_reg [LINE_WORDS];
    logic [ADDR_WIDTH-1:0] req_adr_reg;
    logic [31:0]           req_dat_reg;
    logic [3:0]            req_sel_reg;
    logic [31:0]           dat_reg;

    logic                capture, fill_wr, line_upd, dat_load;
    logic [31:0]         dat_value;
    logic                slv_req, in_hit, cur_hit, last_beat, slv_gone;
    logic [WORD_W-1:0]   in_word, cur_word;

    assign slv_req   = wbs_cyc_i & wbs_stb_i;
    assign in_word   = wbs_adr_i[OFF_W-1:2];
    assign cur_word  = req_adr_reg[OFF_W-1:2];
    assign in_hit    = valid_reg && (tag_reg == wbs_adr_i[ADDR_WIDTH-1:OFF_W]);
    assign cur_hit   = valid_reg && (tag_reg == req_adr_reg[ADDR_WIDTH-1:OFF_W]);
    assign last_beat = (beat_reg == LAST_BEAT);
    // Once the CPU abandons its cycle mid-transfer, the eventual termination is swallowed.
    assign slv_gone  = abort_reg | ~wbs_cyc_i;

    always_comb begin
        state_next      = state_reg;
        valid_next      = valid_reg;
        ack_next        = 1'b0;
        err_next        = 1'b0;
        abort_next      = abort_reg;
        flush_pend_next = flush_pend_reg;
        beat_next       = beat_reg;
        capture         = 1'b0;
        fill_wr         = 1'b0;
        line_upd        = 1'b0;
        dat_load        = 1'b0;
        dat_value       = line_reg[in_word];

        unique case (state_reg)
            IDLE: begin
                abort_next      = 1'b0;
                flush_pend_next = 1'b0;
                beat_next       = '0;
                if (slv_req) begin
                    capture = 1'b1;
                    if (wbs_we_i) begin
                        state_next = WRITE;
                    end else if (in_hit) begin
                        state_next = RESP;
                        ack_next   = 1'b1;
                        dat_load   = 1'b1;
                    end else begin
                        state_next = FILL;
                        valid_next = 1'b0;
                    end
                end
            end
            FILL: begin
                if (!wbs_cyc_i) abort_next = 1'b1;
                if (flush_i)    flush_pend_next = 1'b1;
                if (wbm_err_i) begin
                    state_next = RESP;
                    err_next   = ~slv_gone;
                    valid_next = 1'b0;
                end else if (wbm_ack_i) begin
                    fill_wr   = 1'b1;
                    beat_next = beat_reg + 1'b1;
                    if (beat_reg == cur_word) begin
                        dat_load  = 1'b1;
                        dat_value = wbm_dat_i;
                    end
                    if (last_beat) begin
                        state_next = RESP;
                        ack_next   = ~slv_gone;
                        valid_next = ~(flush_pend_reg | flush_i);
                    end
                end
            end
            WRITE: begin
                if (!wbs_cyc_i) abort_next = 1'b1;
                if (wbm_err_i) begin
                    state_next = RESP;
                    err_next   = ~slv_gone;
                end else if (wbm_ack_i) begin
                    state_next = RESP;
                    ack_next   = ~slv_gone;
                    line_upd   = cur_hit;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase

        // During FILL a flush is deferred so it also covers the line being loaded.
        if (flush_i && state_reg != FILL) valid_next = 1'b0;
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_reg      <= IDLE;
            valid_reg      <= 1'b0;
            ack_reg        <= 1'b0;
            err_reg        <= 1'b0;
            abort_reg      <= 1'b0;
            flush_pend_reg <= 1'b0;
            beat_reg       <= '0;
        end else begin
            state_reg      <= state_next;
            valid_reg      <= valid_next;
            ack_reg        <= ack_next;
            err_reg        <= err_next;
            abort_reg      <= abort_next;
            flush_pend_reg <= flush_pend_next;
            beat_reg       <= beat_next;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (capture) begin
            req_adr_reg <= wbs_adr_i;
            req_dat_reg <= wbs_dat_i;
            req_sel_reg <= wbs_sel_i;
        end
        if (dat_load) dat_reg <= dat_value;
        if (fill_wr) begin
            line_reg[beat_reg] <= wbm_dat_i;
            if (last_beat) tag_reg <= req_adr_reg[ADDR_WIDTH-1:OFF_W];
        end
        if (line_upd) line_reg[cur_word] <= byte_merge(line_reg[cur_word], req_dat_reg, req_sel_reg);
    end

    assign wbs_dat_o = dat_reg;
    assign wbs_ack_o = ack_reg;
    assign wbs_err_o = err_reg;

    // Master controls decode straight from state so an async reset drops the bus immediately.
    assign wbm_cyc_o = (state_reg == FILL) || (state_reg == WRITE);
    assign wbm_stb_o = wbm_cyc_o;
    assign wbm_we_o  = (state_reg == WRITE);
    assign wbm_adr_o = (state_reg == FILL) ? {req_adr_reg[ADDR_WIDTH-1:OFF_W], beat_reg, 2'b00}
                                           : req_adr_reg;
    assign wbm_dat_o = req_dat_reg;
    assign wbm_sel_o = (state_reg == FILL) ? 4'hF : req_sel_reg;
    assign wbm_cti_o = (state_reg == FILL) ? (last_beat ? CTI_EOB : CTI_INCR) : CTI_CLASSIC;
    assign wbm_bte_o = BTE_LINEAR;

endmodule

// File: doc/wb_line_buffer.md
WB_LINE_BUFFER -- requirements
Module: wb_line_buffer

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 32, meaning the byte-address width on both ports.
REQ-002 The block SHALL have parameter LINE_WORDS, default 8, meaning 32-bit words per line; it SHALL equal the SDRAM burst length and be a power of two.
REQ-003 The block SHALL have port wb_clk_i, input, 1 bit: the single clock.
REQ-004 The block SHALL have port wb_rst_i, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have slave ports wbs_cyc_i, wbs_stb_i and wbs_we_i, input, 1 bit each: CPU-side Wishbone classic controls.
REQ-006 The block SHALL have port wbs_adr_i (input, ADDR_WIDTH), wbs_dat_i (input, 32), wbs_sel_i (input, 4): CPU address, write data and byte enables.
REQ-007 The block SHALL have port wbs_dat_o (output, 32), wbs_ack_o (output, 1) and wbs_err_o (output, 1): CPU read data and termination.
REQ-008 The block SHALL have master ports wbm_cyc_o, wbm_stb_o and wbm_we_o (output, 1 each), wbm_adr_o (output, ADDR_WIDTH), wbm_dat_o (output, 32), wbm_sel_o (output, 4), wbm_cti_o (output, 3) and wbm_bte_o (output, 2): the SDRAM-controller-side Wishbone B3 burst master.
REQ-009 The block SHALL have ports wbm_dat_i (input, 32), wbm_ack_i (input, 1) and wbm_err_i (input, 1): SDRAM-controller responses.
REQ-010 The block SHALL have port flush_i, input, 1 bit: a one-cycle line-invalidate request.

Function
REQ-011 The block SHALL hold one line: a valid bit, a tag of adr[ADDR_WIDTH-1:log2(LINE_WORDS)+2] and LINE_WORDS x 32 data registers.
REQ-012 The FSM SHALL have the states IDLE, FILL, WRITE and RESP.
REQ-013 In IDLE, when cyc&stb&!we hits a valid line, the block SHALL assert wbs_ack_o for exactly one cycle on the next clock, with wbs_dat_o equal to the addressed word (read-hit latency 1).
REQ-014 On a read miss, the block SHALL enter FILL, clear valid, and issue an incrementing burst from the line base address.
REQ-015 During FILL, wbm_bte_o SHALL be 00, wbm_sel_o SHALL be 1111, and wbm_cti_o SHALL be 010 for beats 0..LINE_WORDS-2 and 111 for the last beat.
REQ-016 During FILL, wbm_adr_o SHALL advance by 4 on each wbm_ack_i.
REQ-017 After the last fill ack, the block SHALL set valid, load the tag, and go to RESP; RESP SHALL assert wbs_ack_o for one cycle with the requested word, then return to IDLE.
REQ-018 A write in IDLE SHALL go to WRITE and forward a single write (cti 000) with the slave dat/sel/adr.
REQ-019 In WRITE, wbs_ack_o SHALL be asserted in the cycle after wbm_ack_i.
REQ-020 If a write hits the line, the selected bytes in the line SHALL be updated in the cycle the master ack is seen (write-through, no allocate on miss).
REQ-021 If wbm_err_i occurs in FILL or WRITE, the block SHALL drop wbm_cyc_o at once, leave valid at 0 for FILL, and pulse wbs_err_o instead of wbs_ack_o.
REQ-022 If wbs_cyc_i drops mid-FILL, the burst SHALL complete, the line SHALL become valid, and no slave termination SHALL be issued.
REQ-023 flush_i SHALL clear valid on the next clock. If flush_i is asserted during FILL, the fill SHALL complete and the RESP ack SHALL still be given, but valid SHALL stay 0.
REQ-024 If flush_i coincides with a read hit in IDLE, the hit SHALL be served and valid cleared afterwards.
REQ-025 wbm_cyc_o and wbm_stb_o SHALL be asserted only in FILL and WRITE, and held until the final ack or an error.
REQ-026 A new slave request SHALL be sampled only in IDLE; wbs_ack_o and wbs_err_o SHALL never be asserted together.

Reset
REQ-027 On wb_rst_i, the block SHALL asynchronously enter IDLE and clear valid, wbs_ack_o, wbs_err_o, wbm_cyc_o, wbm_stb_o and wbm_we_o, with wbm_cti_o=000 and wbm_bte_o=00. Data and tag registers need not be reset.
REQ-028 Reset mid-FILL SHALL abandon the burst with wbm_cyc_o low in the same cycle; the line SHALL be invalid after release.

Structure
REQ-029 The FSM state encoding and the CTI/BTE constants (CLASSIC=000, INCR=010, EOB=111, LINEAR=00) SHALL reside in a shared package, wb_pkg.
REQ-030 The block SHALL be a single module with no sub-modules; the line storage SHALL be a register array.

Verification
REQ-031 Reset then read 0x0000_0100 (miss) -> 8-beat burst at 0x100..0x11C with cti 010x7 then 111; slave ack with beat-0 data one cycle after the last master ack.
REQ-032 Read 0x104 after REQ-031 -> no master cycle; ack 1 cycle after stb with beat-1 data.
REQ-033 Write 0x108 = 0xDEADBEEF with sel 0011 -> a single master write with cti 000; then read 0x108 -> hit returning old[31:16] concatenated with 0xBEEF.
REQ-034 Assert wbm_err_i on beat 3 of a fill -> wbm_cyc_o drops that cycle, wbs_err_o pulses once, and a repeated read of the same address misses.
REQ-035 Pulse flush_i mid-fill and drop wbs_cyc_i mid-fill in separate runs -> the burst completes both times; a subsequent read of the same line misses in the flush run and hits in the cyc-drop run.
REQ-036 Assert wb_rst_i at beat 5 of a fill -> wbm_cyc_o goes low asynchronously; after release, a read of the same line re-fills from the line base.
